// File: rtl/deserializer_framed.sv
// Framed multi-lane serial-to-parallel converter with a valid/ready output holding register.
module deserializer_framed #(
    parameter int unsigned LENGTH    = 24,
    parameter int unsigned LANES     = 1,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_din_valid,
    input  logic [LANES-1:0]  iv_din,
    input  logic              i_din_last,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_frame_err,
    output logic              o_overflow
);

    localparam int unsigned BEATS = LENGTH / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // Reject configurations where the word cannot be split into whole beats.
    generate
        if (LANES == 0 || LANES > LENGTH || (LENGTH % LANES) != 0) begin : g_bad_cfg
            $error("deserializer_framed: LENGTH must be a non-zero multiple of LANES");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LENGTH-1:0] shift_q, shift_d;
    logic [LENGTH-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic [LENGTH-1:0] word_c;
    logic              accept_c;
    logic              at_last_c;

    // Word as it would look after absorbing the current beat; after BEATS beats
    // every stale bit has been shifted out, so no clearing between words is needed.
    generate
        if (BEATS == 1) begin : g_single
            assign word_c = iv_din;
        end else if (LSB_FIRST) begin : g_lsb
            assign word_c = {iv_din, shift_q[LENGTH-1:LANES]};
        end else begin : g_msb
            assign word_c = {shift_q[LENGTH-LANES-1:0], iv_din};
        end
    endgenerate

    assign accept_c  = i_en && i_din_valid;
    assign at_last_c = (cnt_q == LAST_BEAT);

    // Beat counting, framing checks and output holding-register control.
    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;

        if (dout_valid_q && i_dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (accept_c) begin
            shift_d = word_c;
            if (at_last_c) begin
                cnt_d = '0;
                if (i_din_last) begin
                    if (!dout_valid_q || i_dout_ready) begin
                        dout_d       = word_c;
                        dout_valid_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    shift_d     = '0;
                end
            end else if (i_din_last) begin
                cnt_d       = '0;
                frame_err_d = 1'b1;
                shift_d     = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ov_dout      = dout_q;
    assign o_dout_valid = dout_valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_deserializer_framed.sv
// Directed bench for deserializer_framed: single-lane LSB-first unit plus two 4-lane units.
module tb_deserializer_framed;

    logic clk = 1'b0;
    logic rst;

    // Single-lane, LSB-first instance.
    logic        a_en, a_valid, a_din, a_last, a_ready;
    logic [23:0] a_dout;
    logic        a_dvalid, a_ferr, a_ovf;

    // Two 4-lane instances sharing stimulus, differing in bit order.
    logic        b_valid, b_last;
    logic [3:0]  b_din;
    logic [23:0] bm_dout, bl_dout;
    logic        bm_dvalid, bm_ferr, bm_ovf;
    logic        bl_dvalid, bl_ferr, bl_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int a_ferr_cnt = 0;
    int a_ovf_cnt  = 0;

    deserializer_framed #(.LENGTH(24), .LANES(1), .LSB_FIRST(1'b1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_en(a_en), .i_din_valid(a_valid), .iv_din(a_din),
        .i_din_last(a_last), .ov_dout(a_dout), .o_dout_valid(a_dvalid),
        .i_dout_ready(a_ready), .o_frame_err(a_ferr), .o_overflow(a_ovf)
    );

    deserializer_framed #(.LENGTH(24), .LANES(4), .LSB_FIRST(1'b0)) u_bm (
        .i_clk(clk), .i_rst(rst), .i_en(1'b1), .i_din_valid(b_valid), .iv_din(b_din),
        .i_din_last(b_last), .ov_dout(bm_dout), .o_dout_valid(bm_dvalid),
        .i_dout_ready(1'b1), .o_frame_err(bm_ferr), .o_overflow(bm_ovf)
    );

    deserializer_framed #(.LENGTH(24), .LANES(4), .LSB_FIRST(1'b1)) u_bl (
        .i_clk(clk), .i_rst(rst), .i_en(1'b1), .i_din_valid(b_valid), .iv_din(b_din),
        .i_din_last(b_last), .ov_dout(bl_dout), .o_dout_valid(bl_dvalid),
        .i_dout_ready(1'b1), .o_frame_err(bl_ferr), .o_overflow(bl_ovf)
    );

    always #5 clk = ~clk;

    // Pulse counters for the single-lane unit, sampled away from the active edge.
    always @(negedge clk) begin
        if (a_ferr) a_ferr_cnt = a_ferr_cnt + 1;
        if (a_ovf)  a_ovf_cnt  = a_ovf_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp)
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat1(input logic d, input logic last);
        a_valid = 1'b1;
        a_din   = d;
        a_last  = last;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    // Send beats 0..n-1 of w; last asserted on beat last_at.
    task automatic send1(input logic [23:0] w, input int n, input int last_at);
        for (int k = 0; k < n; k++) beat1(w[k], (k == last_at));
    endtask

    task automatic beat4(input logic [3:0] d, input logic last);
        b_valid = 1'b1;
        b_din   = d;
        b_last  = last;
        tick();
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    initial begin
        logic [23:0] w;
        logic [23:0] words [6];
        int ferr_snap, ovf_snap;

        rst = 1'b1;
        a_en = 1'b1; a_valid = 1'b0; a_din = 1'b0; a_last = 1'b0; a_ready = 1'b1;
        b_valid = 1'b0; b_din = 4'h0; b_last = 1'b0;
        tick();
        tick();
        chk("rst_dout", 32'(a_dout), 32'h0);
        chk("rst_valid", 32'(a_dvalid), 32'h0);
        chk("rst_ferr", 32'(a_ferr), 32'h0);
        chk("rst_ovf", 32'(a_ovf), 32'h0);
        rst = 1'b0;
        tick();

        // 1: single-lane LSB-first word, latency one clock after the final beat
        w = 24'hA5C3F0;
        for (int k = 0; k < 23; k++) beat1(w[k], 1'b0);
        chk("t1_valid_before_last", 32'(a_dvalid), 32'h0);
        beat1(w[23], 1'b1);
        chk("t1_valid", 32'(a_dvalid), 32'h1);
        chk("t1_dout", 32'(a_dout), 32'hA5C3F0);
        chk("t1_ferr", 32'(a_ferr), 32'h0);
        tick();
        chk("t1_consumed", 32'(a_dvalid), 32'h0);

        // 2: four lanes, both bit orders from the same beats
        for (int k = 0; k < 6; k++) beat4(4'(k + 1), (k == 5));
        chk("t2_msb_valid", 32'(bm_dvalid), 32'h1);
        chk("t2_msb_dout", 32'(bm_dout), 32'h123456);
        chk("t2_lsb_valid", 32'(bl_dvalid), 32'h1);
        chk("t2_lsb_dout", 32'(bl_dout), 32'h654321);
        chk("t2_ferr", 32'({bm_ferr, bl_ferr}), 32'h0);

        // 2b: missing last on the final 4-lane beat
        for (int k = 0; k < 6; k++) beat4(4'hF, 1'b0);
        chk("t2_missing_last_ferr", 32'({bm_ferr, bl_ferr}), 32'h3);
        chk("t2_missing_last_valid", 32'({bm_dvalid, bl_dvalid}), 32'h0);

        // 3: early last on beat 10, then a good word
        w = 24'h00FFFF;
        send1(w, 11, 10);
        chk("t3_ferr_pulse", 32'(a_ferr), 32'h1);
        chk("t3_valid_after_err", 32'(a_dvalid), 32'h0);
        tick();
        chk("t3_ferr_one_cycle", 32'(a_ferr), 32'h0);
        send1(w, 24, 23);
        chk("t3_dout", 32'(a_dout), 32'h00FFFF);
        chk("t3_valid", 32'(a_dvalid), 32'h1);
        tick();
        chk("t3_consumed", 32'(a_dvalid), 32'h0);

        // 4: holding register full -> overflow on second completion
        a_ready = 1'b0;
        send1(24'h111111, 24, 23);
        chk("t4_first_valid", 32'(a_dvalid), 32'h1);
        chk("t4_first_dout", 32'(a_dout), 32'h111111);
        chk("t4_first_ovf", 32'(a_ovf), 32'h0);
        send1(24'h222222, 24, 23);
        chk("t4_ovf_pulse", 32'(a_ovf), 32'h1);
        chk("t4_dout_held", 32'(a_dout), 32'h111111);
        chk("t4_valid_held", 32'(a_dvalid), 32'h1);
        tick();
        chk("t4_ovf_one_cycle", 32'(a_ovf), 32'h0);
        chk("t4_still_valid", 32'(a_dvalid), 32'h1);
        a_ready = 1'b1;
        tick();
        chk("t4_handshake_clears", 32'(a_dvalid), 32'h0);
        chk("t4_dout_after", 32'(a_dout), 32'h111111);

        // 5: reset mid-word discards the partial word
        send1(24'hFFFFFF, 12, 99);
        chk("t5_no_err_mid", 32'(a_ferr), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_dout", 32'(a_dout), 32'h0);
        chk("t5_rst_valid", 32'(a_dvalid), 32'h0);
        ferr_snap = a_ferr_cnt;
        send1(24'h5A5A5A, 24, 23);
        chk("t5_dout", 32'(a_dout), 32'h5A5A5A);
        chk("t5_valid", 32'(a_dvalid), 32'h1);
        chk("t5_no_ferr", 32'(a_ferr_cnt - ferr_snap), 32'h0);
        tick();

        // 6: back-to-back words with disabled and idle gaps, ready held high
        words[0] = 24'h000000; words[1] = 24'hFFFFFF; words[2] = 24'h123456;
        words[3] = 24'hABCDEF; words[4] = 24'h800001; words[5] = 24'h3C5AA5;
        ferr_snap = a_ferr_cnt;
        ovf_snap  = a_ovf_cnt;
        for (int i = 0; i < 6; i++) begin
            w = words[i];
            for (int k = 0; k < 24; k++) begin
                if (((k + i) % 5) == 2) begin
                    a_en = 1'b0; a_valid = 1'b1; a_din = ~w[k]; a_last = 1'b1;
                    tick();
                    a_en = 1'b1; a_valid = 1'b0; a_last = 1'b0;
                end
                if (((k + i) % 7) == 3) tick();
                beat1(w[k], (k == 23));
            end
            chk($sformatf("t6_dout_%0d", i), 32'(a_dout), 32'(words[i]));
            chk($sformatf("t6_valid_%0d", i), 32'(a_dvalid), 32'h1);
        end
        tick();
        chk("t6_no_ferr", 32'(a_ferr_cnt - ferr_snap), 32'h0);
        chk("t6_no_ovf", 32'(a_ovf_cnt - ovf_snap), 32'h0);
        chk("t6_drained", 32'(a_dvalid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
